// File: rtl/text_memory_loader.sv
// ============================================================================
// Module   : text_memory_loader
// Brief    : Byte-stream to text-memory loader; assembles little-endian words
//            and holds the core while a program image is written.
//            Optional trailing checksum byte: define TEXT_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_memory_loader #(
    parameter int TEXT_WORDS = 16384,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_data,
    output logic                  mem_write_enable,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
`ifdef TEXT_LOADER_CHECKSUM_EN
        , S_CHECK = 3'd6
`endif
    } state_t;

    localparam logic [16:0] C_MAX_WORDS = 17'(TEXT_WORDS);
    localparam logic [ADDR_WIDTH:0] C_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [15:0]           len_q, len_d;
    logic [31:0]           word_q, word_d;
    logic                  rx_ready_q, rx_ready_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [31:0]           mem_data_q, mem_data_d;
    logic                  mem_we_q, mem_we_d;
    logic                  core_hold_q, core_hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH:0]   words_written_q, words_written_d;
`ifdef TEXT_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic                  w_accept;
    logic [15:0]           w_len_full;
    logic [ADDR_WIDTH:0]   w_ww_inc;
    logic                  w_to_finish;
    logic                  w_to_done;
    logic                  w_to_error;

    assign w_accept   = rx_valid & rx_ready_q;
    assign w_len_full = {rx_data, len_q[7:0]};
    assign w_ww_inc   = words_written_q + C_ONE;

    always_comb begin
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        len_d           = len_q;
        word_d          = word_q;
        mem_address_d   = mem_address_q;
        mem_data_d      = mem_data_q;
        mem_we_d        = 1'b0;
        core_hold_d     = core_hold_q;
        busy_d          = busy_q;
        done_d          = done_q;
        error_d         = error_q;
        words_written_d = words_written_q;
`ifdef TEXT_LOADER_CHECKSUM_EN
        sum_d           = sum_q;
`endif
        w_to_finish     = 1'b0;
        w_to_done       = 1'b0;
        w_to_error      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d         = S_LEN;
                    busy_d          = 1'b1;
                    core_hold_d     = 1'b1;
                    done_d          = 1'b0;
                    error_d         = 1'b0;
                    words_written_d = '0;
                    byte_cnt_d      = 2'd0;
`ifdef TEXT_LOADER_CHECKSUM_EN
                    sum_d           = 8'h00;
`endif
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    if (byte_cnt_q == 2'd0) begin
                        len_d[7:0] = rx_data;
                        byte_cnt_d = 2'd1;
                    end else begin
                        len_d      = w_len_full;
                        byte_cnt_d = 2'd0;
                        if (w_len_full == 16'd0) begin
                            w_to_finish = 1'b1;
                        end else if ({1'b0, w_len_full} > C_MAX_WORDS) begin
                            w_to_error = 1'b1;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    word_d[8*byte_cnt_q +: 8] = rx_data;
`ifdef TEXT_LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Word and address are captured here so the strobe cycle sees them stable.
                        mem_data_d    = word_d;
                        mem_address_d = words_written_q[ADDR_WIDTH-1:0];
                        mem_we_d      = 1'b1;
                        byte_cnt_d    = 2'd0;
                        state_d       = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                words_written_d = w_ww_inc;
                if (16'(w_ww_inc) == len_q) begin
                    w_to_finish = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef TEXT_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_accept) begin
                    if (rx_data == sum_q) begin
                        w_to_done = 1'b1;
                    end else begin
                        w_to_error = 1'b1;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef TEXT_LOADER_CHECKSUM_EN
        if (w_to_finish) begin
            state_d = S_CHECK;
        end
`else
        if (w_to_finish) begin
            w_to_done = 1'b1;
        end
`endif
        if (w_to_done) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            core_hold_d = 1'b0;
            done_d      = 1'b1;
        end
        if (w_to_error) begin
            state_d     = S_ERROR;
            busy_d      = 1'b0;
            core_hold_d = 1'b0;
            error_d     = 1'b1;
        end

        // Ready is a function of the upcoming state only, so it never depends on rx_valid.
        rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA)
`ifdef TEXT_LOADER_CHECKSUM_EN
                     || (state_d == S_CHECK)
`endif
                     ;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            byte_cnt_q      <= 2'd0;
            len_q           <= 16'd0;
            word_q          <= 32'd0;
            rx_ready_q      <= 1'b0;
            mem_address_q   <= '0;
            mem_data_q      <= 32'd0;
            mem_we_q        <= 1'b0;
            core_hold_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            words_written_q <= '0;
`ifdef TEXT_LOADER_CHECKSUM_EN
            sum_q           <= 8'h00;
`endif
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            len_q           <= len_d;
            word_q          <= word_d;
            rx_ready_q      <= rx_ready_d;
            mem_address_q   <= mem_address_d;
            mem_data_q      <= mem_data_d;
            mem_we_q        <= mem_we_d;
            core_hold_q     <= core_hold_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            words_written_q <= words_written_d;
`ifdef TEXT_LOADER_CHECKSUM_EN
            sum_q           <= sum_d;
`endif
        end
    end

    assign rx_ready         = rx_ready_q;
    assign mem_address      = mem_address_q;
    assign mem_data         = mem_data_q;
    assign mem_write_enable = mem_we_q;
    assign core_hold        = core_hold_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign words_written    = words_written_q;

endmodule

`default_nettype wire

// File: tb/tb_text_memory_loader.sv
// ============================================================================
// Module   : tb_text_memory_loader
// Brief    : Scoreboard bench for text_memory_loader (both checksum builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_text_memory_loader;

    localparam int ADDR_WIDTH = 14;

    logic                  clock;
    logic                  reset;
    logic                  start;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data;
    logic                  mem_write_enable;
    logic                  core_hold;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   words_written;

    int n_tests = 0;
    int n_fail  = 0;
    int strobes = 0;
    int bad_hold = 0;
    int bad_ready = 0;
    logic [45:0] exp_q[$];

    text_memory_loader #(.TEXT_WORDS(16384), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .mem_write_enable (mem_write_enable),
        .core_hold        (core_hold),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .words_written    (words_written)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write-port scoreboard plus handshake invariants, sampled mid-cycle.
    always @(negedge clock) begin
        if (core_hold !== busy) bad_hold++;
        if (busy && (rx_ready == mem_write_enable)) bad_ready++;
        if (mem_write_enable) begin
            strobes++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_strobe", 32'(mem_address), 32'hFFFF_FFFF);
            end else begin
                logic [45:0] e;
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(mem_address), 32'(e[45:32]));
                check_eq("wr_data", mem_data, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        for (k = 0; k < 100 && !rx_ready; k++) @(negedge clock);
        if (!rx_ready) check_eq("ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_hold", 32'(core_hold), 32'd1);
        check_eq("start_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic wait_end(input logic exp_done, input logic exp_err, input int exp_ww);
        int k;
        for (k = 0; k < 300 && busy; k++) @(negedge clock);
        check_eq("end_timeout", 32'(busy), 32'd0);
        check_eq("end_done", 32'(done), 32'(exp_done));
        check_eq("end_error", 32'(error), 32'(exp_err));
        check_eq("end_hold", 32'(core_hold), 32'd0);
        check_eq("end_words", 32'(words_written), 32'(exp_ww));
        repeat (2) @(negedge clock);
        check_eq("idle_ready", 32'(rx_ready), 32'd0);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("hold_tracks_busy", 32'(bad_hold), 32'd0);
        check_eq("ready_vs_strobe", 32'(bad_ready), 32'd0);
    endtask

    task automatic two_word_load(input int gap);
        int s0;
        s0 = strobes;
        do_start();
        exp_q.push_back({14'd0, 32'h0000_0013});
        exp_q.push_back({14'd1, 32'h0010_0093});
        send_byte(8'h02, gap); send_byte(8'h00, gap);
        send_byte(8'h13, gap); send_byte(8'h00, gap);
        send_byte(8'h00, gap); send_byte(8'h00, gap);
        send_byte(8'h93, gap); send_byte(8'h00, gap);
        send_byte(8'h10, gap); send_byte(8'h00, gap);
`ifdef TEXT_LOADER_CHECKSUM_EN
        send_byte(8'hB6, gap);
`endif
        wait_end(1'b1, 1'b0, 2);
        check_eq("two_word_strobes", 32'(strobes - s0), 32'd2);
    endtask

    initial begin
        int s0;
        reset    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_hold", 32'(core_hold), 32'd0);
        check_eq("rst_done_err", 32'({done, error}), 32'd0);
        check_eq("rst_ready", 32'(rx_ready), 32'd0);
        check_eq("rst_mem", mem_data | 32'(mem_address) | 32'(mem_write_enable), 32'd0);
        check_eq("rst_words", 32'(words_written), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        two_word_load(0);
        two_word_load(3);

        // Oversized length rejected without any write.
        s0 = strobes;
        do_start();
        send_byte(8'h01, 0); send_byte(8'h41, 0);
        wait_end(1'b0, 1'b1, 0);
        check_eq("oversize_strobes", 32'(strobes - s0), 32'd0);

        // Empty image.
        s0 = strobes;
        do_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef TEXT_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
        wait_end(1'b1, 1'b0, 0);
        do_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        wait_end(1'b0, 1'b1, 0);
`else
        wait_end(1'b1, 1'b0, 0);
`endif
        check_eq("empty_strobes", 32'(strobes - s0), 32'd0);

        // Asynchronous abort mid-word, then a clean single-word reload.
        s0 = strobes;
        do_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_busy_hold", 32'({busy, core_hold}), 32'd0);
        check_eq("abort_ready", 32'(rx_ready), 32'd0);
        check_eq("abort_done_err", 32'({done, error}), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        check_eq("abort_strobes", 32'(strobes - s0), 32'd0);
        do_start();
        exp_q.push_back({14'd0, 32'hDEAD_BEEF});
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0);
        send_byte(8'hAD, 0); send_byte(8'hDE, 0);
`ifdef TEXT_LOADER_CHECKSUM_EN
        send_byte(8'h38, 0);
`endif
        wait_end(1'b1, 1'b0, 1);
        check_eq("reload_strobes", 32'(strobes - s0), 32'd1);

`ifdef TEXT_LOADER_CHECKSUM_EN
        for (int t = 0; t < 2; t++) begin
            do_start();
            exp_q.push_back({14'd0, 32'h0403_0201});
            send_byte(8'h01, 0); send_byte(8'h00, 0);
            send_byte(8'h01, 0); send_byte(8'h02, 0);
            send_byte(8'h03, 0); send_byte(8'h04, 0);
            send_byte((t == 0) ? 8'h0A : 8'h0B, 0);
            wait_end(t == 0, t != 0, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
